// File: rtl/keccak_squeezer.sv
`default_nettype none
// ============================================================================
// Module   : keccak_squeezer
// Purpose  : Squeeze stage of the Keccak core. Captures the permuted state and
//            streams rate lanes as output words, asking for extra
//            permutations in XOF modes.
// Revision : 1.0 - initial release
// ============================================================================
module keccak_squeezer #(
    parameter int LANE_W   = 64,
    parameter int MAX_RATE = 21,
    parameter int LEN_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [LEN_W-1:0]     xof_words,
    input  logic [25*LANE_W-1:0] state_in,
    input  logic                 state_valid,
    output logic                 perm_req,
    output logic [LANE_W-1:0]    out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W  = $clog2(MAX_RATE);
    localparam int NLANES = 25;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_ST = 3'd1,
        ST_EMIT    = 3'd2,
        ST_REQ     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t             state_q;
    logic [LANE_W-1:0]  buf_q [MAX_RATE];
    logic [IDX_W-1:0]   rate_q;
    logic [IDX_W-1:0]   word_idx_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [LANE_W-1:0]  out_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               perm_req_q;
    logic               busy_q;
    logic               done_q;

    logic [IDX_W-1:0]   rate_d;
    logic [LEN_W-1:0]   len_d;
    logic [IDX_W-1:0]   idx_d;
    logic [LEN_W-1:0]   rem_d;
    logic               unused_lanes;

    // Lanes above the largest rate belong to the capacity and are never emitted.
    assign unused_lanes = ^state_in[NLANES*LANE_W-1:MAX_RATE*LANE_W];

    always_comb begin
        rate_d = IDX_W'(9);
        len_d  = LEN_W'(8);
        unique case (mode)
            2'd0: begin rate_d = IDX_W'(9);  len_d = LEN_W'(8); end
            2'd1: begin rate_d = IDX_W'(17); len_d = LEN_W'(4); end
            2'd2: begin rate_d = IDX_W'(21); len_d = xof_words; end
            2'd3: begin rate_d = IDX_W'(17); len_d = xof_words; end
            default: ;
        endcase
    end

    assign idx_d = word_idx_q + IDX_W'(1);
    assign rem_d = remaining_q - LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rate_q      <= '0;
            word_idx_q  <= '0;
            remaining_q <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            perm_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < MAX_RATE; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            perm_req_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rate_q      <= rate_d;
                        remaining_q <= len_d;
                        busy_q      <= 1'b1;
                        if (len_d == '0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_WAIT_ST;
                        end
                    end
                end
                ST_WAIT_ST: begin
                    if (state_valid) begin
                        for (int i = 0; i < MAX_RATE; i++) begin
                            if (IDX_W'(i) < rate_q) begin
                                buf_q[i] <= state_in[i*LANE_W +: LANE_W];
                            end
                        end
                        // Lane 0 goes straight to the output so the first word
                        // appears the cycle after capture.
                        word_idx_q  <= '0;
                        out_q       <= state_in[LANE_W-1:0];
                        out_valid_q <= 1'b1;
                        out_last_q  <= (remaining_q == LEN_W'(1));
                        state_q     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        remaining_q <= rem_d;
                        word_idx_q  <= idx_d;
                        if (remaining_q == LEN_W'(1)) begin
                            out_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (word_idx_q == rate_q - IDX_W'(1)) begin
                            out_q       <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            perm_req_q  <= 1'b1;
                            state_q     <= ST_REQ;
                        end else begin
                            out_q      <= buf_q[idx_d];
                            out_last_q <= (rem_d == LEN_W'(1));
                        end
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT_ST;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign perm_req  = perm_req_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire
